// File: rtl/idli_decode_queue_m_pkg.sv
// -----------------------------------------------------------------------------
// idli_decode_queue_m_pkg
// Shared types for the IDLI decode queue.
//   ctr_t      : 2-bit position inside the 4-cycle SQI period (3 = last cycle)
//   data_t     : 16-bit instruction / immediate word
//   dq_entry_t : one queue slot (word plus instruction/immediate classification)
//   need_imm_f : tells whether an instruction word is followed by an immediate
// -----------------------------------------------------------------------------
package idli_decode_queue_m_pkg;

   typedef logic [1:0]  ctr_t;
   typedef logic [15:0] data_t;

   localparam ctr_t CTR_LAST = 2'd3;

   typedef struct packed {
      data_t word;
      logic  is_imm;
      logic  need_imm;
   } dq_entry_t;

   // Opcode 4'hF carries an immediate except for the four short forms below.
   function automatic logic need_imm_f(input data_t word);
      logic short_form;
      short_form = (word[3:0] == 4'b1000) || (word[3:0] == 4'b1001) ||
                   (word[3:0] == 4'b1010) || (word[3:0] == 4'b1101);
      return (word[15:12] == 4'hF) && !short_form;
   endfunction

endpackage

// File: rtl/idli_decode_queue_m_if.sv
// -----------------------------------------------------------------------------
// idli_decode_queue_m_if
// Fetcher/consumer side bundle of the decode queue.
//   i_dq_ctr, i_dq_sqi, i_dq_sqi_vld, i_dq_flush, i_dq_rdy : into the queue
//   o_dq_enc, o_dq_imm, o_dq_has_imm, o_dq_vld, o_dq_full  : out of the queue
// master = fetcher/consumer, slave = the queue itself.
// -----------------------------------------------------------------------------
interface idli_decode_queue_m_if;
   import idli_decode_queue_m_pkg::*;

   ctr_t       i_dq_ctr;
   logic [3:0] i_dq_sqi;
   logic       i_dq_sqi_vld;
   logic       i_dq_flush;
   logic       i_dq_rdy;
   data_t      o_dq_enc;
   data_t      o_dq_imm;
   logic       o_dq_has_imm;
   logic       o_dq_vld;
   logic       o_dq_full;

   modport master (
      output i_dq_ctr, i_dq_sqi, i_dq_sqi_vld, i_dq_flush, i_dq_rdy,
      input  o_dq_enc, o_dq_imm, o_dq_has_imm, o_dq_vld, o_dq_full
   );

   modport slave (
      input  i_dq_ctr, i_dq_sqi, i_dq_sqi_vld, i_dq_flush, i_dq_rdy,
      output o_dq_enc, o_dq_imm, o_dq_has_imm, o_dq_vld, o_dq_full
   );
endinterface

// File: rtl/idli_decode_queue_m_asm.sv
// -----------------------------------------------------------------------------
// idli_dq_asm_m
// Collects four SQI nibbles (ctr 0..3, low nibble first) into a 16-bit word.
//   i_gck/i_rst : clock, synchronous active-high reset
//   i_clr       : discard the partial word (flush)
//   i_ctr, i_sqi, i_sqi_vld : period position and nibble
//   o_word      : assembled word, meaningful at ctr==3
//   o_complete  : all four nibbles of this period were valid (ctr==3 only)
// -----------------------------------------------------------------------------
module idli_dq_asm_m
   import idli_decode_queue_m_pkg::*;
(
   input  logic       i_gck,
   input  logic       i_rst,
   input  logic       i_clr,
   input  ctr_t       i_ctr,
   input  logic [3:0] i_sqi,
   input  logic       i_sqi_vld,
   output data_t      o_word,
   output logic       o_complete
);

   logic [11:0] part_r;
   logic        ok_r;

   // Nibble capture; ok_r restarts at ctr 0 so a reset or flush mid-period
   // spoils only the current period.
   always_ff @(posedge i_gck) begin
      if (i_rst || i_clr) begin
         part_r <= 12'h000;
         ok_r   <= 1'b0;
      end else begin
         case (i_ctr)
            2'd0: begin
               part_r[3:0] <= i_sqi;
               ok_r        <= i_sqi_vld;
            end
            2'd1: begin
               part_r[7:4] <= i_sqi;
               ok_r        <= ok_r & i_sqi_vld;
            end
            2'd2: begin
               part_r[11:8] <= i_sqi;
               ok_r         <= ok_r & i_sqi_vld;
            end
            default: ok_r <= 1'b0;
         endcase
      end
   end

   // The top nibble comes straight from the input in the last cycle.
   always_comb begin
      o_word     = {i_sqi, part_r};
      o_complete = (i_ctr == CTR_LAST) && ok_r && i_sqi_vld;
   end

endmodule

// File: rtl/idli_decode_queue_m_chk.sv
// -----------------------------------------------------------------------------
// idli_dq_chk_m
// Simulation checks for the decode queue.
//   i_gck/i_rst : clock and reset
//   i_drop      : a complete word arrived while full with no pop (fetcher error)
// -----------------------------------------------------------------------------
module idli_dq_chk_m (
   input logic i_gck,
   input logic i_rst,
   input logic i_drop
);

   a_no_overflow: assert property (@(posedge i_gck) disable iff (i_rst) !i_drop);

endmodule

// File: rtl/idli_decode_queue_m.sv
// -----------------------------------------------------------------------------
// idli_decode_queue_m
// Decode queue between the SQI fetcher and the decoder. Words are assembled
// from nibbles, classified as instruction or immediate, and held in a
// DEPTH-entry circular buffer. The head instruction is presented together
// with its immediate once both are present.
//   DEPTH      : entries, power of two, >= 2
//   i_dq_gck   : clock
//   i_dq_rst   : synchronous active-high reset
//   dq (slave) : SQI input, flush, consumer ready, head outputs, full
// Optional build macro IDLI_DQ_BYPASS_EN: with the queue empty, a completing
// instruction without immediate is presented in its own arrival cycle and,
// when the consumer is ready, taken without being stored.
// -----------------------------------------------------------------------------
module idli_decode_queue_m
   import idli_decode_queue_m_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic                  i_dq_gck,
   input logic                  i_dq_rst,
   idli_decode_queue_m_if.slave dq
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   dq_entry_t mem_r [DEPTH];
   ptr_t      rd_ptr_r;
   ptr_t      wr_ptr_r;
   cnt_t      count_r;
   logic      pend_imm_r;

   data_t     asm_word_s;
   logic      asm_complete_s;
   dq_entry_t head_s;
   dq_entry_t next_s;
   logic      last_s;
   logic      full_s;
   logic      head_vld_s;
   logic      word_need_s;
   logic      byp_s;
   logic      byp_take_s;
   logic      pop_s;
   logic      push_s;
   logic      drop_s;
   cnt_t      pop_n_s;
   cnt_t      push_n_s;

   idli_dq_asm_m u_asm (
      .i_gck      (i_dq_gck),
      .i_rst      (i_dq_rst),
      .i_clr      (dq.i_dq_flush),
      .i_ctr      (dq.i_dq_ctr),
      .i_sqi      (dq.i_dq_sqi),
      .i_sqi_vld  (dq.i_dq_sqi_vld),
      .o_word     (asm_word_s),
      .o_complete (asm_complete_s)
   );

   // Head decode, bypass detection and push/pop decisions for this cycle.
   always_comb begin
      last_s      = (dq.i_dq_ctr == CTR_LAST);
      full_s      = (count_r == cnt_t'(DEPTH));
      head_s      = mem_r[rd_ptr_r];
      next_s      = mem_r[rd_ptr_r + ptr_t'(1)];
      head_vld_s  = (count_r != cnt_t'(0)) && !head_s.is_imm &&
                    (!head_s.need_imm || ((count_r >= cnt_t'(2)) && next_s.is_imm));
      word_need_s = need_imm_f(asm_word_s);
`ifdef IDLI_DQ_BYPASS_EN
      byp_s       = asm_complete_s && (count_r == cnt_t'(0)) && !pend_imm_r &&
                    !word_need_s && !i_dq_rst && !dq.i_dq_flush;
`else
      byp_s       = 1'b0;
`endif
      byp_take_s  = byp_s && dq.i_dq_rdy;
      pop_s       = last_s && head_vld_s && dq.i_dq_rdy;
      if (pop_s) begin
         pop_n_s = head_s.need_imm ? cnt_t'(2) : cnt_t'(1);
      end else begin
         pop_n_s = cnt_t'(0);
      end
      // A full queue still accepts when the head leaves at the same edge.
      push_s      = asm_complete_s && !byp_take_s && (!full_s || pop_s);
      drop_s      = asm_complete_s && !byp_take_s && full_s && !pop_s && !dq.i_dq_flush;
      push_n_s    = push_s ? cnt_t'(1) : cnt_t'(0);
   end

   // Head presentation; everything reads zero while nothing is valid.
   always_comb begin
      dq.o_dq_full = full_s;
      if (byp_s) begin
         dq.o_dq_vld     = 1'b1;
         dq.o_dq_enc     = asm_word_s;
         dq.o_dq_has_imm = 1'b0;
         dq.o_dq_imm     = 16'h0000;
      end else if (head_vld_s) begin
         dq.o_dq_vld     = 1'b1;
         dq.o_dq_enc     = head_s.word;
         dq.o_dq_has_imm = head_s.need_imm;
         dq.o_dq_imm     = head_s.need_imm ? next_s.word : 16'h0000;
      end else begin
         dq.o_dq_vld     = 1'b0;
         dq.o_dq_enc     = 16'h0000;
         dq.o_dq_has_imm = 1'b0;
         dq.o_dq_imm     = 16'h0000;
      end
   end

   // Storage, pointers, occupancy and the pending-immediate flag; flush wins.
   always_ff @(posedge i_dq_gck) begin
      if (i_dq_rst) begin
         rd_ptr_r   <= ptr_t'(0);
         wr_ptr_r   <= ptr_t'(0);
         count_r    <= cnt_t'(0);
         pend_imm_r <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '{word: 16'h0000, is_imm: 1'b0, need_imm: 1'b0};
         end
      end else if (dq.i_dq_flush) begin
         rd_ptr_r   <= ptr_t'(0);
         wr_ptr_r   <= ptr_t'(0);
         count_r    <= cnt_t'(0);
         pend_imm_r <= 1'b0;
      end else begin
         if (push_s) begin
            // A word following an immediate-carrying instruction is its immediate.
            mem_r[wr_ptr_r] <= '{word:     asm_word_s,
                                 is_imm:   pend_imm_r,
                                 need_imm: !pend_imm_r && word_need_s};
            wr_ptr_r        <= wr_ptr_r + ptr_t'(1);
            pend_imm_r      <= !pend_imm_r && word_need_s;
         end else begin
            pend_imm_r      <= pend_imm_r;
         end
         rd_ptr_r <= rd_ptr_r + ptr_t'(pop_n_s);
         count_r  <= count_r + push_n_s - pop_n_s;
      end
   end

   idli_dq_chk_m u_chk (
      .i_gck  (i_dq_gck),
      .i_rst  (i_dq_rst),
      .i_drop (drop_s)
   );

endmodule

// File: tb/tb_idli_decode_queue_m.sv
// -----------------------------------------------------------------------------
// tb_idli_decode_queue_m
// Self-checking bench for idli_decode_queue_m (DEPTH=4): a table of directed
// periods with hand-computed results, a bypass-latency sequence, then random
// periods compared every cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_idli_decode_queue_m;
   import idli_decode_queue_m_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   idli_decode_queue_m_if dq_if ();

   idli_decode_queue_m #(.DEPTH(DEPTH)) dut (
      .i_dq_gck (clk),
      .i_dq_rst (rst),
      .dq       (dq_if.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: queue of classified words.
   typedef struct {
      logic [15:0] w;
      bit          imm;
      bit          need;
   } ment_t;

   ment_t      mq[$];
   bit         m_pend = 1'b0;
   bit         m_good = 1'b0;
   logic [3:0] m_nib [3];

   // Directed table: one SQI period per row, expectations at the next ctr 0.
   typedef struct {
      logic [15:0] w;
      logic [3:0]  mask;
      bit          rdy;
      int          fl_at;
      int          rs_at;
      bit          ev;
      logic [15:0] ee;
      bit          eh;
      logic [15:0] ei;
      bit          ef;
   } row_t;

   row_t tbl [18];
   row_t texp;
   bit   tpend     = 1'b0;
   int   tidx      = 0;
   bit   chk_byp   = 1'b0;
   bit   exp_byp;

   function automatic bit spec_need(input logic [15:0] w);
      return (w[15:12] == 4'hF) &&
             !(w[3:0] inside {4'b1000, 4'b1001, 4'b1010, 4'b1101});
   endfunction

   function automatic bit m_head_vld();
      if (mq.size() == 0) return 1'b0;
      if (mq[0].imm) return 1'b0;
      if (!mq[0].need) return 1'b1;
      return (mq.size() >= 2) && mq[1].imm;
   endfunction

   function automatic bit m_bypass(input logic [1:0] c, input logic [3:0] n,
                                   input logic v, input logic f, input logic rs);
      bit cpl;
      logic [15:0] w;
      cpl = (c == 2'd3) && m_good && v;
      w   = {n, m_nib[2], m_nib[1], m_nib[0]};
`ifdef IDLI_DQ_BYPASS_EN
      return cpl && (mq.size() == 0) && !m_pend && !spec_need(w) && !rs && !f;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check_out(input string nm, input logic ev, input logic [15:0] ee,
                            input logic eh, input logic [15:0] ei, input logic ef);
      n_checks++;
      if (dq_if.o_dq_vld !== ev || dq_if.o_dq_enc !== ee || dq_if.o_dq_has_imm !== eh ||
          dq_if.o_dq_imm !== ei || dq_if.o_dq_full !== ef) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got vld=%0b enc=%h has=%0b imm=%h full=%0b want vld=%0b enc=%h has=%0b imm=%h full=%0b",
                  nm, cyc, dq_if.o_dq_vld, dq_if.o_dq_enc, dq_if.o_dq_has_imm,
                  dq_if.o_dq_imm, dq_if.o_dq_full, ev, ee, eh, ei, ef);
      end
   endtask

   task automatic model_check(input logic [1:0] c, input logic [3:0] n, input logic v,
                              input logic f, input logic rs);
      bit hv;
      logic [15:0] w;
      hv = m_head_vld();
      w  = {n, m_nib[2], m_nib[1], m_nib[0]};
      if (m_bypass(c, n, v, f, rs)) begin
         check_out("model", 1'b1, w, 1'b0, 16'h0000, mq.size() == DEPTH);
      end else if (hv) begin
         check_out("model", 1'b1, mq[0].w, mq[0].need,
                   mq[0].need ? mq[1].w : 16'h0000, mq.size() == DEPTH);
      end else begin
         check_out("model", 1'b0, 16'h0000, 1'b0, 16'h0000, mq.size() == DEPTH);
      end
   endtask

   task automatic model_update(input logic [1:0] c, input logic [3:0] n, input logic v,
                               input logic f, input logic rs, input logic r);
      bit hv, byp, cpl, pop;
      logic [15:0] w;
      int npop;
      if (rs || f) begin
         mq.delete();
         m_pend = 1'b0;
         m_good = 1'b0;
      end else begin
         hv  = m_head_vld();
         byp = m_bypass(c, n, v, f, rs);
         cpl = (c == 2'd3) && m_good && v;
         w   = {n, m_nib[2], m_nib[1], m_nib[0]};
         pop = (c == 2'd3) && hv && r;
         if (pop) begin
            npop = mq[0].need ? 2 : 1;
            for (int i = 0; i < npop; i++) void'(mq.pop_front());
         end
         if (cpl && !(byp && r)) begin
            n_checks++;
            if (mq.size() >= DEPTH) begin
               n_errors++;
               $display("FAIL stimulus_overflow cyc=%0d got size=%0d want below %0d",
                        cyc, mq.size(), DEPTH);
            end else begin
               mq.push_back('{w: w, imm: m_pend, need: !m_pend && spec_need(w)});
               m_pend = !m_pend && spec_need(w);
            end
         end
         if (c == 2'd0) m_good = v;
         else if (c == 2'd3) m_good = 1'b0;
         else m_good = m_good && v;
         if (c != 2'd3) m_nib[c] = n;
      end
   endtask

   task automatic step(input logic [3:0] n, input logic v, input logic f,
                       input logic rs, input logic r);
      logic [1:0] c;
      c = cyc[1:0];
      @(negedge clk);
      dq_if.i_dq_ctr     = c;
      dq_if.i_dq_sqi     = n;
      dq_if.i_dq_sqi_vld = v;
      dq_if.i_dq_flush   = f;
      dq_if.i_dq_rdy     = r;
      rst                = rs;
      #1;
      model_check(c, n, v, f, rs);
      if (tpend && c == 2'd0) begin
         check_out($sformatf("table%0d", tidx), texp.ev, texp.ee, texp.eh, texp.ei, texp.ef);
         tpend = 1'b0;
      end
      if (chk_byp && c == 2'd3) begin
         n_checks++;
         if (dq_if.o_dq_vld !== exp_byp) begin
            n_errors++;
            $display("FAIL bypass_latency got vld=%0b want %0b", dq_if.o_dq_vld, exp_byp);
         end
         chk_byp = 1'b0;
      end
      model_update(c, n, v, f, rs, r);
      cyc++;
   endtask

   task automatic period(input logic [15:0] w, input logic [3:0] mask, input logic r,
                         input int fl_at, input int rs_at);
      for (int k = 0; k < 4; k++) begin
         step(w[4*k +: 4], mask[k], fl_at == k, rs_at == k, r);
      end
   endtask

   task automatic do_reset();
      for (int k = 0; k < 8; k++) step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      texp  = '{w: 16'h0000, mask: 4'h0, rdy: 1'b0, fl_at: 4, rs_at: 4,
                ev: 1'b0, ee: 16'h0000, eh: 1'b0, ei: 16'h0000, ef: 1'b0};
      tidx  = 99;
      tpend = 1'b1;
   endtask

   initial begin
      logic [15:0] rw;
      logic [3:0]  rmask;
      logic        rrdy;
      int          rfl, rrs;

      dq_if.i_dq_ctr     = 2'd0;
      dq_if.i_dq_sqi     = 4'h0;
      dq_if.i_dq_sqi_vld = 1'b0;
      dq_if.i_dq_flush   = 1'b0;
      dq_if.i_dq_rdy     = 1'b0;

      //             word      mask  rdy  fl rs  vld enc       has imm       full
      tbl[0]  = '{16'h0012, 4'hF, 1'b0, 4, 4, 1'b1, 16'h0012, 1'b0, 16'h0000, 1'b0};
      tbl[1]  = '{16'h0034, 4'hF, 1'b0, 4, 4, 1'b1, 16'h0012, 1'b0, 16'h0000, 1'b0};
      tbl[2]  = '{16'h0056, 4'hF, 1'b0, 4, 4, 1'b1, 16'h0012, 1'b0, 16'h0000, 1'b0};
      tbl[3]  = '{16'h0078, 4'hF, 1'b0, 4, 4, 1'b1, 16'h0012, 1'b0, 16'h0000, 1'b1};
      tbl[4]  = '{16'h0099, 4'hF, 1'b1, 4, 4, 1'b1, 16'h0034, 1'b0, 16'h0000, 1'b1};
      tbl[5]  = '{16'hF002, 4'hF, 1'b1, 4, 4, 1'b1, 16'h0056, 1'b0, 16'h0000, 1'b1};
      tbl[6]  = '{16'h00AA, 4'hF, 1'b1, 3, 4, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[7]  = '{16'hF002, 4'hF, 1'b0, 4, 4, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[8]  = '{16'hBEEF, 4'hF, 1'b0, 4, 4, 1'b1, 16'hF002, 1'b1, 16'hBEEF, 1'b0};
      tbl[9]  = '{16'h0000, 4'h0, 1'b1, 4, 4, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[10] = '{16'h0123, 4'hF, 1'b0, 4, 4, 1'b1, 16'h0123, 1'b0, 16'h0000, 1'b0};
      tbl[11] = '{16'h0456, 4'hD, 1'b0, 4, 4, 1'b1, 16'h0123, 1'b0, 16'h0000, 1'b0};
      tbl[12] = '{16'h0789, 4'hF, 1'b0, 4, 2, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      tbl[13] = '{16'h0ABC, 4'hF, 1'b0, 4, 4, 1'b1, 16'h0ABC, 1'b0, 16'h0000, 1'b0};
      tbl[14] = '{16'hF00D, 4'hF, 1'b1, 4, 4, 1'b1, 16'hF00D, 1'b0, 16'h0000, 1'b0};
      tbl[15] = '{16'h1234, 4'hF, 1'b1, 4, 4, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0};
      tbl[16] = '{16'hFFF1, 4'hF, 1'b0, 4, 4, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0};
      tbl[17] = '{16'h5555, 4'hF, 1'b1, 4, 4, 1'b1, 16'hFFF1, 1'b1, 16'h5555, 1'b0};

      // Reset state, then bypass/latency on an empty queue.
      do_reset();
`ifdef IDLI_DQ_BYPASS_EN
      exp_byp = 1'b1;
`else
      exp_byp = 1'b0;
`endif
      chk_byp = 1'b1;
      period(16'h0012, 4'hF, 1'b0, 4, 4);
      texp  = '{16'h0012, 4'hF, 1'b0, 4, 4, 1'b1, 16'h0012, 1'b0, 16'h0000, 1'b0};
      tidx  = 98;
      tpend = 1'b1;

      // Directed table.
      do_reset();
      for (int i = 0; i < 18; i++) begin
         period(tbl[i].w, tbl[i].mask, tbl[i].rdy, tbl[i].fl_at, tbl[i].rs_at);
         texp  = tbl[i];
         tidx  = i;
         tpend = 1'b1;
      end
      period(16'h0000, 4'h0, 1'b0, 4, 4);

      // Random periods against the model.
      do_reset();
      for (int p = 0; p < 400; p++) begin
         rw = 16'($urandom);
         if ($urandom_range(0, 1) == 0) rw[15:12] = 4'hF;
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0: rw[3:0] = 4'b1000;
               1: rw[3:0] = 4'b1001;
               2: rw[3:0] = 4'b1010;
               default: rw[3:0] = 4'b1101;
            endcase
         end
         rrdy  = 1'($urandom_range(0, 1));
         rmask = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
         if (mq.size() == DEPTH && !rrdy) rmask = 4'h0;
         rfl   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : 4;
         rrs   = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 3)) : 4;
         period(rw, rmask, rrdy, rfl, rrs);
      end
      period(16'h0000, 4'h0, 1'b1, 4, 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/idli_decode_queue_m.md
IDLI_DECODE_QUEUE_M -- requirements
Module: idli_decode_queue_m

Interface
REQ-001 Parameter DEPTH, default 4, number of 16b word entries; SHALL be a power of two and at least 2.
REQ-002 i_dq_gck  input  1  the one clock, all state on posedge.
REQ-003 i_dq_rst  input  1  reset; synchronous and active-high.
REQ-004 i_dq_ctr  input  ctr_t(2)  sync counter; value 3 marks the last cycle of a 4-cycle period.
REQ-005 i_dq_sqi  input  4  SQI nibble for the current cycle.
REQ-006 i_dq_sqi_vld  input  1  current nibble valid.
REQ-007 i_dq_flush  input  1  discard all queued and partial state (redirect).
REQ-008 i_dq_rdy  input  1  consumer accepts the head instruction at ctr==3.
REQ-009 o_dq_enc  output  data_t(16)  head instruction encoding.
REQ-010 o_dq_imm  output  data_t(16)  immediate paired with the head; zero when none.
REQ-011 o_dq_has_imm  output  1  head carries an immediate.
REQ-012 o_dq_vld  output  1  head instruction, plus its immediate if required, is present.
REQ-013 o_dq_full  output  1  no free entry; the fetcher SHALL hold SQI.

Function
REQ-014 Assembly: a nibble arriving at ctr k SHALL land in word bits [4k+3:4k]. The word is complete at ctr==3 only if i_dq_sqi_vld was high on all four cycles of the period.
REQ-015 An incomplete period SHALL discard the partial word with no push.
REQ-016 Push: a complete word SHALL be written at the ctr==3 edge when not full, or when full with a pop in the same cycle.
REQ-017 A push while full without a pop SHALL be dropped. The overflow is a fetcher protocol error; it SHALL assert in simulation.
REQ-018 Classification: a pushed word is an immediate if the previous pushed word was an instruction requiring one; otherwise it is an instruction.
REQ-019 An instruction requires an immediate when word[15:12]==4'hF and word[3:0] is not in {4'b1000, 4'b1001, 4'b1010, 4'b1101}.
REQ-020 Head valid: o_dq_vld SHALL be high when the head entry is an instruction and, if it requires an immediate, the next entry holds that immediate.
REQ-021 Pop: at ctr==3 with o_dq_vld and i_dq_rdy high, the SHALL remove 1 entry, or 2 if has_imm; pointers wrap modulo DEPTH.
REQ-022 Occupancy SHALL update as count + push - pops, with simultaneous push and pop permitted at any occupancy.
REQ-023 o_dq_full SHALL be high when count==DEPTH.
REQ-024 Pops and pushes occur only at ctr==3. Outputs SHALL be stable for ctr 0..2.
REQ-025 Flush SHALL win over push and pop in the same cycle. It clears the count, pointers, the pending-immediate flag and the partial word; o_dq_vld is low from the next cycle.
REQ-026 o_dq_enc/o_dq_imm SHALL read zero when o_dq_vld is low.

Reset
REQ-027 While i_dq_rst is high at a clock edge, the following SHALL be cleared: count, read pointer, write pointer, pending-immediate flag and partial word.
REQ-028 After reset, o_dq_vld=0, o_dq_full=0, o_dq_has_imm=0, o_dq_enc=0, o_dq_imm=0.
REQ-029 Reset mid-period SHALL discard the partial word. Assembly SHALL restart at the next ctr==0.

Configuration
REQ-030 Macro IDLI_DQ_BYPASS_EN. When defined, with the queue empty and no pending immediate, a word completing at ctr==3 that is an instruction not requiring an immediate SHALL drive o_dq_vld/o_dq_enc combinationally in that same cycle.
REQ-031 With IDLI_DQ_BYPASS_EN and i_dq_rdy high, that bypassed word SHALL be consumed without being pushed. Otherwise it is pushed normally.
REQ-032 Without IDLI_DQ_BYPASS_EN, the earliest o_dq_vld SHALL be the cycle after the push edge, i.e. a 4-cycle latency from the last nibble to accept.

Structure
REQ-033 The package SHALL hold dq_entry_t {data_t word; logic is_imm; logic need_imm} and the function computing need_imm from a word.
REQ-034 The nibble assembler SHALL be a sub-module idli_dq_asm_m, outputting the 16b word and a complete flag.
REQ-035 The queue storage and pointers SHALL reside in idli_decode_queue_m.

Verification
REQ-036 Reset then four periods of words 16'h0012, 16'h0034, 16'h0056, 16'h0078 with rdy=0 -> o_dq_full=1 after the 4th push; o_dq_enc=16'h0012 with DEPTH=4.
REQ-037 Instruction 16'hF002 then 16'hBEEF -> o_dq_vld stays low until 16'hBEEF is pushed; then o_dq_has_imm=1 and o_dq_imm=16'hBEEF; one accept empties the queue.
REQ-038 Queue full and rdy=1 with a new word 16'h0099 arriving -> the head pops and 16'h0099 is pushed at the same edge; the count stays at 4; there is no drop.
REQ-039 Flush asserted at ctr==3 coincident with push and pop -> the count is 0 next cycle and o_dq_vld=0; a subsequent 16'hF002 is classified as an instruction.
REQ-040 sqi_vld low at ctr 1 of a period -> no push; reset pulsed at ctr 2 -> all outputs are zero; the next full period pushes normally.
REQ-041 IDLI_DQ_BYPASS_EN defined, queue empty, 16'h0012 arriving -> o_dq_vld=1 at ctr==3 of the arrival period. Undefined -> o_dq_vld=1 first at the following ctr==0.
